data_mem_unit: RTL and testbench
================================

Name: data_mem_unit

Overview:
- Word-addressed data memory with a multi-cycle access sequencer.
- Sits directly downstream of the single-cycle MIPS datapath and consumes its data_adr / data_out / MemRead / MemWrite.
- Returns load data to the datapath's data_in.
- Asserts a stall so the datapath holds its PC and state while an access with LATENCY wait cycles is in flight.

Parameters:
ADDR_BITS, 8, word-index width; memory holds 2**ADDR_BITS 32-bit words.
LATENCY, 2, wait cycles spent in ACCESS per accepted request; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
mem_read  input  1  load request, held by datapath for the whole instruction.
mem_write  input  1  store request, held by datapath for the whole instruction.
adr  input  32  byte address (datapath ALU result).
wdata  input  32  store data (datapath read_data2).
rdata  output  32  registered load data to datapath data_in.
stall  output  1  datapath must not advance PC or write back while high.
err  output  1  sticky error flag.
busy  output  1  high when state is ACCESS or DONE (debug/visibility).

Behaviour:
- Reset, checked at the clock edge:
  - state=IDLE, counter=0, rdata=0, err=0.
  - All memory words are cleared to 0.
  - Any in-flight access is abandoned; a pending store is discarded.
- Word index = adr[ADDR_BITS+1:2]; adr[31:ADDR_BITS+2] is ignored, so addresses alias/wrap.
- Valid request in IDLE:
  - Exactly one of mem_read / mem_write is high, and adr[1:0]==0.
- Invalid request in IDLE:
  - Either mem_read and mem_write are both high, or the request is misaligned.
  - err is set at the next edge and no access occurs.
  - stall stays 0 and memory and rdata are unchanged.
  - err clears only on rst.
- stall is combinational:
  - stall = (IDLE & valid request) | ACCESS.
  - This lets the datapath freeze in the same cycle the request appears.
- FSM:
  - IDLE:
    - On a valid request: latch op, word index and wdata; counter=LATENCY-1; go to ACCESS.
    - Otherwise stay in IDLE.
  - ACCESS:
    - If counter!=0, decrement it and stay.
    - If counter==0: a store writes the latched wdata to mem[index]; a load loads rdata<=mem[index]; go to DONE.
  - DONE:
    - stall=0 and rdata is valid; the datapath completes its instruction at this edge.
    - Go to IDLE unconditionally. The still-asserted request is consumed here and not re-triggered.
- Latency:
  - Request seen in cycle 0; stall is high for cycles 0..LATENCY; DONE in cycle LATENCY+1.
  - Total stall cycles per access = LATENCY+1.
- Inputs change or drop during ACCESS: ignored; the access completes using the latched values.
- rdata holds its value until the next completed load; stores and invalid requests do not alter it.
- A request present in the cycle right after DONE (IDLE) is treated as a new instruction.
- Back-to-back accesses therefore have one non-stalled cycle between them.
- Read-after-write to the same word returns the new data, since the write is committed at least one cycle before any subsequent load can sample.

Test Plan:
1. rst=1 one cycle, then idle → rdata=0, stall=0, err=0, busy=0; a load of adr 0x10 returns 0x00000000.
2. LATENCY=2: store adr=0x0000_0020 wdata=0xDEADBEEF held until stall falls → stall high exactly 3 cycles starting same cycle as request; busy high 3 cycles (ACCESS×2, DONE); then a load of 0x20 returns rdata=0xDEADBEEF in its DONE cycle, with 3 stall cycles.
3. Misaligned load adr=0x0000_0022 → stall stays 0, err=1 from next cycle and persists; rdata unchanged; a following aligned access still works.
4. mem_read=mem_write=1, adr=0x40 → no stall, err=1, mem[0x10] unchanged (verify by subsequent load returns prior value).
5. Aliasing (ADDR_BITS=8): store 0x12345678 to adr=0x0000_0404 → load of adr=0x0000_0004 returns 0x12345678.
6. rst asserted during the second ACCESS cycle of a store of 0xCAFEF00D to 0x30 → next cycle state IDLE, stall=0; load of 0x30 returns 0x00000000. Deasserting mem_write mid-ACCESS without reset still commits the store.

Source files
------------

// File: rtl/data_mem_unit.sv
// Word-addressed data memory with a multi-cycle access sequencer.
// Accepts one load or store from the single-cycle datapath. It holds the
// datapath with 'stall' while the access spends LATENCY wait cycles in
// ACCESS. It then releases the datapath for one DONE cycle and returns
// to IDLE.
module data_mem_unit #(
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] adr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        err,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   localparam int          WORDS    = 2 ** ADDR_BITS;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   state_t                 state;
   state_t                 next_state;
   logic [3:0]             count;
   logic                   op_write;
   logic [ADDR_BITS-1:0]   idx_q;
   logic [31:0]            wdata_q;
   logic [31:0]            mem [WORDS];
   logic                   valid_req;
   logic                   bad_req;
   logic                   commit;

   // Upper address bits are dropped on purpose so addresses wrap.
   logic                   unused_adr_bits;
   assign unused_adr_bits = ^adr[31:ADDR_BITS+2];

   // Classify the request on the bus as acceptable or as an error.
   always_comb begin
      valid_req = (mem_read ^ mem_write) && (adr[1:0] == 2'b00);
      bad_req   = (mem_read && mem_write) ||
                  ((mem_read || mem_write) && (adr[1:0] != 2'b00));
      commit    = (state == ACCESS) && (count == 4'd0);
   end

   // Next-state logic plus stall/busy, so the datapath freezes in the request cycle.
   always_comb begin
      next_state = state;
      stall      = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (valid_req) begin
               next_state = ACCESS;
               stall      = 1'b1;
            end
         end
         ACCESS: begin
            stall = 1'b1;
            busy  = 1'b1;
            if (count == 4'd0) begin
               next_state = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Latch the request and count the wait cycles; load data and sticky error live here too.
   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= 4'd0;
         op_write <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= 32'd0;
         rdata    <= 32'd0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_req) begin
                  count    <= CNT_INIT;
                  op_write <= mem_write;
                  idx_q    <= adr[ADDR_BITS+1:2];
                  wdata_q  <= wdata;
               end else if (bad_req) begin
                  err <= 1'b1;
               end
            end
            ACCESS: begin
               if (count != 4'd0) begin
                  count <= count - 4'd1;
               end else if (!op_write) begin
                  rdata <= mem[idx_q];
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Storage array; cleared on reset, written only when a store finishes its wait.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WORDS; i++) begin
            mem[i] <= 32'd0;
         end
      end else if (commit && op_write) begin
         mem[idx_q] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit.
// A scoreboard queue holds the rdata expected at the end of each accepted
// access, and a small memory model provides the values it expects.
module tb_data_mem_unit;

   localparam int ADDR_BITS = 8;
   localparam int LATENCY   = 2;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] adr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        err;
   logic        busy;

   int          checks;
   int          failures;

   logic [31:0] model_mem [2**ADDR_BITS];
   logic [31:0] model_rdata;
   logic        model_err;
   logic [31:0] exp_q [$];

   data_mem_unit #(
      .ADDR_BITS(ADDR_BITS),
      .LATENCY  (LATENCY)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_read (mem_read),
      .mem_write(mem_write),
      .adr      (adr),
      .wdata    (wdata),
      .rdata    (rdata),
      .stall    (stall),
      .err      (err),
      .busy     (busy)
   );

   // Free-running clock with a 10-time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   function automatic int word_idx(input logic [31:0] a);
      return int'(a[ADDR_BITS+1:2]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2**ADDR_BITS; i++) begin
         model_mem[i] = 32'd0;
      end
      model_rdata = 32'd0;
      model_err   = 1'b0;
      exp_q.delete();
   endtask

   // One valid access. The request is driven just after a rising edge.
   // Stall and busy are sampled on falling edges until stall drops, which
   // is the DONE cycle. The request is released after the DONE edge.
   // If 'drop' is set, the inputs are scrambled during ACCESS.
   task automatic apply_stimulus(input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input bit drop, input string tag);
      int          stall_cycles;
      int          busy_cycles;
      logic [31:0] exp;
      @(posedge clk);
      #1;
      mem_read  = rd;
      mem_write = wr;
      adr       = a;
      wdata     = d;
      if (wr) begin
         model_mem[word_idx(a)] = d;
      end else begin
         model_rdata = model_mem[word_idx(a)];
      end
      exp_q.push_back(model_rdata);
      stall_cycles = 0;
      busy_cycles  = 0;
      @(negedge clk);
      while (stall && stall_cycles < 40) begin
         stall_cycles++;
         if (busy) busy_cycles++;
         if (drop && stall_cycles > 1) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            adr       = $urandom;
            wdata     = $urandom;
         end
         @(negedge clk);
      end
      if (busy) busy_cycles++;
      check_output({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(LATENCY + 1));
      check_output({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(LATENCY + 1));
      exp = exp_q.pop_front();
      check_output({tag, "_rdata"}, rdata, exp);
      @(posedge clk);
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      check_output({tag, "_idle_stall"}, 32'(stall), 32'd0);
   endtask

   // An invalid request must not stall. It raises the sticky error and leaves rdata alone.
   task automatic apply_invalid(input logic rd, input logic wr,
                                input logic [31:0] a, input logic [31:0] d,
                                input string tag);
      @(posedge clk);
      #1;
      mem_read  = rd;
      mem_write = wr;
      adr       = a;
      wdata     = d;
      model_err = 1'b1;
      @(negedge clk);
      check_output({tag, "_stall"}, 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      check_output({tag, "_err"}, 32'(err), 32'(model_err));
      check_output({tag, "_busy"}, 32'(busy), 32'd0);
      check_output({tag, "_rdata"}, rdata, model_rdata);
   endtask

   // Main sequence covering the reset state, timing, errors, aliasing and reset abort.
   initial begin
      logic [31:0] rand_adrs [5];
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      adr       = 32'd0;
      wdata     = 32'd0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_output("reset_rdata", rdata, 32'd0);
      check_output("reset_stall", 32'(stall), 32'd0);
      check_output("reset_err", 32'(err), 32'd0);
      check_output("reset_busy", 32'(busy), 32'd0);
      apply_stimulus(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, "load_cleared");

      $display("[TB] store then load");
      apply_stimulus(1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, "store_20");
      apply_stimulus(1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b0, "load_20");

      $display("[TB] misaligned load");
      apply_invalid(1'b1, 1'b0, 32'h0000_0022, 32'd0, "misaligned");
      repeat (3) @(negedge clk);
      check_output("err_sticky", 32'(err), 32'd1);
      apply_stimulus(1'b0, 1'b1, 32'h0000_0040, 32'h0000_55AA, 1'b0, "store_40");
      check_output("err_after_store", 32'(err), 32'd1);

      $display("[TB] read and write together");
      apply_invalid(1'b1, 1'b1, 32'h0000_0040, 32'h1111_2222, "both_ops");
      apply_stimulus(1'b1, 1'b0, 32'h0000_0040, 32'd0, 1'b0, "load_40");

      $display("[TB] aliasing");
      apply_stimulus(1'b0, 1'b1, 32'h0000_0404, 32'h1234_5678, 1'b0, "store_404");
      apply_stimulus(1'b1, 1'b0, 32'h0000_0004, 32'd0, 1'b0, "load_004");

      $display("[TB] inputs dropped during access");
      apply_stimulus(1'b0, 1'b1, 32'h0000_0050, 32'hA5A5_0F0F, 1'b1, "store_drop");
      apply_stimulus(1'b1, 1'b0, 32'h0000_0050, 32'd0, 1'b0, "load_drop");

      $display("[TB] random mix");
      rand_adrs[0] = 32'h0000_0000;
      rand_adrs[1] = 32'h0000_0004;
      rand_adrs[2] = 32'h0000_0008;
      rand_adrs[3] = 32'h0000_0400;
      rand_adrs[4] = 32'hFFFF_FC08;
      for (int i = 0; i < 10; i++) begin
         logic [31:0] a;
         a = rand_adrs[$urandom_range(0, 4)];
         if ($urandom_range(0, 1) == 1) begin
            apply_stimulus(1'b0, 1'b1, a, $urandom, 1'b0, "rand_store");
         end else begin
            apply_stimulus(1'b1, 1'b0, a, 32'd0, 1'b0, "rand_load");
         end
      end

      $display("[TB] reset during access");
      @(posedge clk);
      #1;
      mem_write = 1'b1;
      adr       = 32'h0000_0030;
      wdata     = 32'hCAFE_F00D;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      mem_write = 1'b0;
      model_reset();
      @(negedge clk);
      check_output("abort_stall", 32'(stall), 32'd0);
      check_output("abort_busy", 32'(busy), 32'd0);
      check_output("abort_err", 32'(err), 32'd0);
      check_output("abort_rdata", rdata, 32'd0);
      apply_stimulus(1'b1, 1'b0, 32'h0000_0030, 32'd0, 1'b0, "load_30_after_rst");
      apply_stimulus(1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b0, "load_20_after_rst");

      check_output("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
